// File: rtl/shift_pkg.sv
// shift_pkg: shared op codes, FSM states and shift-amount clamp
package shift_pkg;
  typedef enum logic [1:0] {OP_SLL, OP_SRL, OP_SRA, OP_ROR} op_t;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
  function automatic logic [3:0] eff_amount(op_t op, logic [7:0] amount);
    return op == OP_ROR ? {1'b0, amount[2:0]} :
           op == OP_SRA ? (amount > 8'd7 ? 4'd7 : amount[3:0]) :
                          (amount > 8'd8 ? 4'd8 : amount[3:0]);
  endfunction
endpackage

// File: rtl/shift_step.sv
// shift_step: one combinational shift/rotate step of 0..7 bits selected by op
module shift_step
  import shift_pkg::*;
(
  input  logic [7:0] acc,
  input  op_t        op,
  input  logic [2:0] step,
  output logic [7:0] nxt
);
  logic [7:0] sll, srl, sra, ror;
  logic [15:0] rot;
  assign sll = acc << step;
  assign srl = acc >> step;
  assign sra = $signed(acc) >>> step;
  assign rot = {acc, acc} >> step;
  assign ror = rot[7:0];
  assign nxt = op == OP_SLL ? sll : op == OP_SRL ? srl : op == OP_SRA ? sra : ror;
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shifter applying up to MAX_STEP bits per cycle with CPU stall
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int MAX_STEP = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [7:0] data_in,
  input  logic [7:0] amount,
  output logic       busywait,
  output logic       done,
  output logic [7:0] result
);
  state_t state, state_nxt;
  op_t op_q;
  logic [7:0] acc, shifted;
  logic [3:0] rem, eff, rem_left;
  logic [2:0] step;
  logic capture;
  assign eff = eff_amount(op_t'(op), amount);
  assign step = rem > 4'(MAX_STEP) ? 3'(MAX_STEP) : rem[2:0];
  assign rem_left = rem - {1'b0, step};
  assign capture = state == ST_IDLE && start;
  shift_step u_step (.acc(acc), .op(op_q), .step(step), .nxt(shifted));
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= ST_IDLE;
    else state <= state_nxt;
  // next state and status decode; zero amounts skip RUN, DONE always lasts one cycle
  always_comb begin
    state_nxt = capture ? (eff == 4'd0 ? ST_DONE : ST_RUN) :
                state == ST_RUN ? (rem_left == 4'd0 ? ST_DONE : ST_RUN) : ST_IDLE;
    busywait = !reset && (capture || state == ST_RUN);
    done = state == ST_DONE;
  end
  // operand capture, stepwise accumulation and result load on the final step
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      acc <= '0;
      rem <= '0;
      op_q <= OP_SLL;
      result <= '0;
    end else if (capture) begin
      acc <= data_in;
      op_q <= op_t'(op);
      rem <= eff;
      if (eff == 4'd0) result <= data_in;
    end else if (state == ST_RUN) begin
      acc <= shifted;
      rem <= rem_left;
      if (rem_left == 4'd0) result <= shifted;
    end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: randomized check of two sequencer instances (MAX_STEP 7 and 1) against a one-shot shift model
module tb_shift_sequencer;
  logic clk = 0, reset = 1, start = 0;
  logic [1:0] op = 0;
  logic [7:0] data_in = 0, amount = 0;
  logic busy7, done7, busy1, done1;
  logic [7:0] res7, res1;
  logic [7:0] hold7 = 0, hold1 = 0;
  int npass = 0, ntotal = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.MAX_STEP(7)) u7 (.clk(clk), .reset(reset), .start(start), .op(op), .data_in(data_in),
    .amount(amount), .busywait(busy7), .done(done7), .result(res7));
  shift_sequencer #(.MAX_STEP(1)) u1 (.clk(clk), .reset(reset), .start(start), .op(op), .data_in(data_in),
    .amount(amount), .busywait(busy1), .done(done1), .result(res1));

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    ntotal++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %02h expected %02h", tag, got, exp);
  endtask

  function automatic int eff_ref(int o, int a);
    return o == 3 ? a % 8 : o == 2 ? (a < 7 ? a : 7) : (a < 8 ? a : 8);
  endfunction

  function automatic logic [7:0] ref_shift(int o, int d, int a);
    int r, sd;
    r = a % 8;
    sd = d >= 128 ? d - 256 : d;
    case (o)
      0: return a >= 8 ? 8'h00 : 8'(d << a);
      1: return a >= 8 ? 8'h00 : 8'(d >> a);
      2: return a >= 7 ? (d >= 128 ? 8'hFF : 8'h00) : 8'(sd >>> a);
      default: return 8'((d >> r) | (d << (8 - r)));
    endcase
  endfunction

  task automatic txn(input logic [1:0] o, input logic [7:0] d, input logic [7:0] a);
    int e, k7, k1, kmin, kmax;
    logic [7:0] r;
    e = eff_ref(int'(o), int'(a));
    k7 = (e + 6) / 7;
    k1 = e;
    kmin = k7 < k1 ? k7 : k1;
    kmax = k7 > k1 ? k7 : k1;
    r = ref_shift(int'(o), int'(d), int'(a));
    @(negedge clk);
    start = 1; op = o; data_in = d; amount = a;
    #1;
    check("busy_cap7", 8'(busy7), 8'd1);
    check("busy_cap1", 8'(busy1), 8'd1);
    for (int j = 0; j <= kmax + 1; j++) begin
      @(negedge clk);
      if (j == k7) hold7 = r;
      if (j == k1) hold1 = r;
      check("done7", 8'(done7), 8'(j == k7));
      check("busy7", 8'(busy7), 8'(j < k7));
      check("res7", res7, hold7);
      check("done1", 8'(done1), 8'(j == k1));
      check("busy1", 8'(busy1), 8'(j < k1));
      check("res1", res1, hold1);
      start = j < kmin - 1 ? 1'($urandom_range(0, 1)) : 1'b0;
      op = 2'($urandom);
      data_in = 8'($urandom);
      amount = 8'($urandom);
    end
    start = 0;
  endtask

  initial begin
    reset = 1; start = 1;
    repeat (2) @(negedge clk);
    check("rst_busy7", 8'(busy7), 8'd0);
    check("rst_busy1", 8'(busy1), 8'd0);
    check("rst_done7", 8'(done7), 8'd0);
    check("rst_res7", res7, 8'h00);
    check("rst_res1", res1, 8'h00);
    start = 0; reset = 0;
    txn(2'd0, 8'h01, 8'd3);   check("t1_sll", res7, 8'h08);
    txn(2'd1, 8'hF0, 8'd12);  check("t2_srl", res7, 8'h00);
    txn(2'd2, 8'h80, 8'd200); check("t3_sra_sign", res7, 8'hFF);
    txn(2'd2, 8'h40, 8'd3);   check("t3_sra", res7, 8'h08);
    txn(2'd3, 8'h81, 8'd9);   check("t4_ror", res7, 8'hC0);
    txn(2'd3, 8'h5A, 8'd16);  check("t4_ror16", res1, 8'h5A);
    txn(2'd0, 8'h5A, 8'd0);   check("t5_zero", res1, 8'h5A);
    // back-to-back with start held high: second request lands in the first IDLE cycle after DONE
    @(negedge clk);
    start = 1; op = 2'd0; data_in = 8'h5A; amount = 8'd0;
    @(negedge clk);
    check("b2b_done7", 8'(done7), 8'd1);
    check("b2b_busy7", 8'(busy7), 8'd0);
    check("b2b_res7", res7, 8'h5A);
    op = 2'd1; data_in = 8'h33; amount = 8'd0;
    @(negedge clk);
    check("b2b_idle_done7", 8'(done7), 8'd0);
    check("b2b_idle_busy7", 8'(busy7), 8'd1);
    check("b2b_hold7", res7, 8'h5A);
    @(negedge clk);
    check("b2b_done2_7", 8'(done7), 8'd1);
    check("b2b_done2_1", 8'(done1), 8'd1);
    check("b2b_res2_7", res7, 8'h33);
    check("b2b_res2_1", res1, 8'h33);
    start = 0;
    @(negedge clk);
    check("b2b_end_done7", 8'(done7), 8'd0);
    check("b2b_end_busy7", 8'(busy7), 8'd0);
    hold7 = 8'h33; hold1 = 8'h33;
    for (int n = 0; n < 80; n++)
      txn(2'($urandom), 8'($urandom),
          $urandom_range(0, 3) == 0 ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 17)));
    // reset mid-RUN on the bit-serial instance, with a start pulse during RUN
    @(negedge clk);
    start = 1; op = 2'd0; data_in = 8'h01; amount = 8'd5;
    @(negedge clk);
    start = 0;
    check("r6_busy1", 8'(busy1), 8'd1);
    @(negedge clk);
    check("r6_res7", res7, 8'h20);
    check("r6_done7", 8'(done7), 8'd1);
    start = 1; data_in = 8'hFF; amount = 8'd1;
    @(negedge clk);
    check("r6_ign_busy1", 8'(busy1), 8'd1);
    check("r6_ign_res1", res1, hold1);
    start = 0; reset = 1;
    #1;
    check("r6_rst_busy1", 8'(busy1), 8'd0);
    check("r6_rst_done1", 8'(done1), 8'd0);
    check("r6_rst_res1", res1, 8'h00);
    check("r6_rst_res7", res7, 8'h00);
    @(negedge clk);
    reset = 0;
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      check("r6_nodone1", 8'(done1), 8'd0);
      check("r6_idle1", 8'(busy1), 8'd0);
      check("r6_res1", res1, 8'h00);
    end
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
